// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-FIFO types and default sizing constants.
// Each FIFO entry holds one received byte and its error flag.
package uart_rx_fifo_pkg;

   localparam int DEFAULT_DEPTH  = 8;
   localparam int DEFAULT_THRESH = 4;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Level counter needs one extra bit so that "full" (== DEPTH) is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of the UART receive FIFO.
// The master modport is the driving environment; slave is the FIFO.
interface uart_rx_fifo_if
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) ();

   localparam int LW = level_width(DEPTH);

   logic [7:0]    data_i;
   logic          rx_int_i;
   logic          err_int_i;
   logic          clr_i;
   logic          rd_ready_i;
   logic          rd_valid_o;
   logic [7:0]    rd_data_o;
   logic          rd_err_o;
   logic [LW-1:0] level_o;
   logic          full_o;
   logic          empty_o;
   logic          overflow_o;
   logic          irq_o;

   modport master (
      output data_i, rx_int_i, err_int_i, clr_i, rd_ready_i,
      input  rd_valid_o, rd_data_o, rd_err_o, level_o,
             full_o, empty_o, overflow_o, irq_o
   );

   modport slave (
      input  data_i, rx_int_i, err_int_i, clr_i, rd_ready_i,
      output rd_valid_o, rd_data_o, rd_err_o, level_o,
             full_o, empty_o, overflow_o, irq_o
   );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 9 entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module uart_rx_fifo_mem
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem_reg [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers good/errored bytes, tracks level, sticky overflow
// and a level-threshold interrupt. Status outputs derive only from registered state.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int THRESH = DEFAULT_THRESH
) (
   input  logic           clk_i,
   input  logic           rst_i,
   uart_rx_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          overflow_reg;

   logic   empty;
   logic   full;
   logic   wr_evt;
   logic   rd_evt;
   logic   accept;
   logic   drop;
   entry_t wr_entry;
   entry_t rd_entry;

   assign empty  = (level_reg == '0);
   assign full   = (level_reg == LW'(DEPTH));
   assign wr_evt = bus.rx_int_i | bus.err_int_i;
   assign rd_evt = ~empty & bus.rd_ready_i;

   // A write into a full FIFO is still accepted when the head leaves on the same edge.
   assign accept = wr_evt & (~full | rd_evt) & ~bus.clr_i;
   assign drop   = wr_evt & full & ~rd_evt & ~bus.clr_i;

   assign wr_entry = '{err: bus.err_int_i, data: bus.data_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (bus.clr_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_evt) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (accept && !rd_evt) begin
            level_reg <= level_reg + LW'(1);
         end else if (!accept && rd_evt) begin
            level_reg <= level_reg - LW'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i (clk_i),
      .we    (accept),
      .waddr (wr_ptr_reg),
      .wdata (wr_entry),
      .raddr (rd_ptr_reg),
      .rdata (rd_entry)
   );

   assign bus.rd_valid_o = ~empty;
   assign bus.rd_data_o  = rd_entry.data;
   assign bus.rd_err_o   = rd_entry.err;
   assign bus.level_o    = level_reg;
   assign bus.full_o     = full;
   assign bus.empty_o    = empty;
   assign bus.overflow_o = overflow_reg;
   assign bus.irq_o      = (level_reg >= LW'(THRESH));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: constant vector table, directed corner
// sequences, and randomized traffic compared against a queue-based reference.
module tb_uart_rx_fifo;
   import uart_rx_fifo_pkg::*;

   localparam int DEPTH  = 8;
   localparam int THRESH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .DEPTH  (DEPTH),
      .THRESH (THRESH)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: a queue of {err,data} entries plus a sticky overflow bit.
   logic [8:0] model_q [$];
   bit         model_ovf;

   typedef struct {
      bit         rx;
      bit         er;
      logic [7:0] d;
      bit         rdy;
      bit         clr;
      bit         e_valid;
      logic [7:0] e_data;
      bit         e_err;
      int         e_level;
      bit         e_ovf;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      n = model_q.size();
      chk({tag, " level"},    32'(bus.level_o),    n);
      chk({tag, " valid"},    32'(bus.rd_valid_o), (n > 0) ? 1 : 0);
      chk({tag, " empty"},    32'(bus.empty_o),    (n == 0) ? 1 : 0);
      chk({tag, " full"},     32'(bus.full_o),     (n == DEPTH) ? 1 : 0);
      chk({tag, " irq"},      32'(bus.irq_o),      (n >= THRESH) ? 1 : 0);
      chk({tag, " overflow"}, 32'(bus.overflow_o), 32'(model_ovf));
      if (n > 0) begin
         chk({tag, " data"}, 32'(bus.rd_data_o), 32'(model_q[0][7:0]));
         chk({tag, " err"},  32'(bus.rd_err_o),  32'(model_q[0][8]));
      end
   endtask

   // One clock transaction: drive inputs, advance the reference, compare after the edge.
   task automatic step(input bit rx, input bit er, input logic [7:0] d,
                       input bit rdy, input bit clr, input string tag);
      bus.rx_int_i   = rx;
      bus.err_int_i  = er;
      bus.data_i     = d;
      bus.rd_ready_i = rdy;
      bus.clr_i      = clr;
      @(posedge clk);
      if (clr) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else begin
         if (rdy && model_q.size() > 0) void'(model_q.pop_front());
         if (rx || er) begin
            if (model_q.size() < DEPTH) model_q.push_back({er, d});
            else model_ovf = 1'b1;
         end
      end
      #1;
      $display("t=%0t %s rx=%0d err=%0d d=%02h rdy=%0d clr=%0d -> level=%0d valid=%0d head=%02h/%0d ovf=%0d irq=%0d",
               $time, tag, rx, er, d, rdy, clr, bus.level_o, bus.rd_valid_o,
               bus.rd_data_o, bus.rd_err_o, bus.overflow_o, bus.irq_o);
      check_model(tag);
   endtask

   task automatic idle_inputs();
      bus.rx_int_i   = 1'b0;
      bus.err_int_i  = 1'b0;
      bus.data_i     = 8'h00;
      bus.rd_ready_i = 1'b0;
      bus.clr_i      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rx er data   rdy clr  valid data   err lvl ovf
      vecs[0]  = '{1, 0, 8'hA5, 0, 0,    1, 8'hA5, 0,  1,  0};
      vecs[1]  = '{0, 0, 8'h00, 1, 0,    0, 8'h00, 0,  0,  0};
      vecs[2]  = '{1, 0, 8'h11, 0, 0,    1, 8'h11, 0,  1,  0};
      vecs[3]  = '{0, 1, 8'h22, 0, 0,    1, 8'h11, 0,  2,  0};
      vecs[4]  = '{1, 1, 8'h33, 0, 0,    1, 8'h11, 0,  3,  0};
      vecs[5]  = '{0, 0, 8'h00, 1, 0,    1, 8'h22, 1,  2,  0};
      vecs[6]  = '{0, 0, 8'h00, 1, 0,    1, 8'h33, 1,  1,  0};
      vecs[7]  = '{0, 0, 8'h00, 1, 0,    0, 8'h00, 0,  0,  0};
      vecs[8]  = '{0, 0, 8'h00, 1, 0,    0, 8'h00, 0,  0,  0};
      vecs[9]  = '{1, 0, 8'h44, 1, 0,    1, 8'h44, 0,  1,  0};
      vecs[10] = '{1, 0, 8'h55, 0, 1,    0, 8'h00, 0,  0,  0};

      idle_inputs();
      model_ovf = 1'b0;
      rst = 1'b1;
      #1;
      check_model("reset_async");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].rx, vecs[i].er, vecs[i].d, vecs[i].rdy, vecs[i].clr, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_valid", i), 32'(bus.rd_valid_o), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d tbl_level", i), 32'(bus.level_o),    vecs[i].e_level);
         chk($sformatf("vec%0d tbl_ovf", i),   32'(bus.overflow_o), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d tbl_empty", i), 32'(bus.empty_o),    32'(!vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d tbl_data", i), 32'(bus.rd_data_o), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d tbl_err", i),  32'(bus.rd_err_o),  32'(vecs[i].e_err));
         end
      end

      // Overflow: nine writes into an eight-entry FIFO
      for (int i = 0; i < DEPTH + 1; i++) begin
         step(1, 0, 8'(i + 1), 0, 0, "ovf_fill");
         if (i == DEPTH - 1) chk("ovf_full_at_8", 32'(bus.full_o), 1);
      end
      chk("ovf_sticky", 32'(bus.overflow_o), 1);
      chk("ovf_level", 32'(bus.level_o), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         chk("ovf_drain_order", 32'(bus.rd_data_o), 32'(i + 1));
         step(0, 0, 8'h00, 1, 0, "ovf_drain");
      end
      chk("ovf_ninth_absent", 32'(bus.empty_o), 1);

      // Full with simultaneous read and write
      step(0, 0, 8'h00, 0, 1, "clr");
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h10 + i), 0, 0, "full_fill");
      step(1, 0, 8'h77, 1, 0, "full_rw");
      chk("full_rw_level", 32'(bus.level_o), DEPTH);
      chk("full_rw_ovf", 32'(bus.overflow_o), 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("full_rw_order", 32'(bus.rd_data_o), (i == DEPTH - 1) ? 32'h77 : 32'(8'h11 + i));
         step(0, 0, 8'h00, 1, 0, "full_rw_drain");
      end

      // Steady-state streaming at level 3 with pointer wrap
      step(0, 0, 8'h00, 0, 1, "clr");
      for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0, 0, "stream_pre");
      for (int k = 0; k < 20; k++) begin
         step(1, 0, 8'(8'h80 + k), 1, 0, "stream");
         chk("stream_level", 32'(bus.level_o), 3);
         chk("stream_irq", 32'(bus.irq_o), 0);
      end
      for (int i = 0; i < 3; i++) begin
         chk("stream_tail", 32'(bus.rd_data_o), 32'(8'h91 + i));
         step(0, 0, 8'h00, 1, 0, "stream_drain");
      end

      // Flush overrides a same-cycle write and clears overflow
      for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'(8'h20 + i), 0, 0, "clr_fill");
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, "clr_read");
      chk("pre_clr_level", 32'(bus.level_o), 5);
      chk("pre_clr_ovf", 32'(bus.overflow_o), 1);
      step(1, 0, 8'h99, 1, 1, "clr_wr");
      chk("clr_level", 32'(bus.level_o), 0);
      chk("clr_ovf", 32'(bus.overflow_o), 0);
      chk("clr_irq", 32'(bus.irq_o), 0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 8'(8'h40 + i), 0, 0, "burst");
      #2;
      rst = 1'b1;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      chk("arst_valid", 32'(bus.rd_valid_o), 0);
      chk("arst_level", 32'(bus.level_o), 0);
      chk("arst_empty", 32'(bus.empty_o), 1);
      chk("arst_full", 32'(bus.full_o), 0);
      chk("arst_ovf", 32'(bus.overflow_o), 0);
      chk("arst_irq", 32'(bus.irq_o), 0);
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1, 0, 8'h5A, 0, 0, "post_rst");
      chk("post_rst_head", 32'(bus.rd_data_o), 32'h5A);
      chk("post_rst_level", 32'(bus.level_o), 1);

      // Randomized traffic against the reference queue
      for (int n = 0; n < 400; n++) begin
         bit rx, er, rdy, clr;
         rx  = ($urandom_range(0, 99) < 55);
         er  = ($urandom_range(0, 99) < 15);
         rdy = ($urandom_range(0, 99) < 45);
         clr = ($urandom_range(0, 99) < 3);
         step(rx, er, 8'($urandom), rdy, clr, "rand");
      end

      idle_inputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, 2..256.
REQ-002 Parameter THRESH, default 4, level at or above which irq_o asserts; range 1..DEPTH.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 data_i  input  8  received byte from the UART receiver.
REQ-006 rx_int_i  input  1  one-cycle pulse: data_i holds a good byte.
REQ-007 err_int_i  input  1  one-cycle pulse: data_i holds a byte with parity/CRC/stop error.
REQ-008 clr_i  input  1  synchronous flush, also clears overflow.
REQ-009 rd_ready_i  input  1  consumer accepts the head entry.
REQ-010 rd_valid_o  output  1  head entry available.
REQ-011 rd_data_o  output  8  head entry byte.
REQ-012 rd_err_o  output  1  head entry error flag.
REQ-013 level_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 full_o / empty_o  output  1 each  level==DEPTH / level==0.
REQ-015 overflow_o  output  1  sticky: an entry was dropped.
REQ-016 irq_o  output  1  level_o >= THRESH.

Function
REQ-017 Write event = rx_int_i OR err_int_i; each write stores {err_int_i, data_i} as one entry.
REQ-018 rx_int_i and err_int_i in the same cycle SHALL produce one entry with err=1.
REQ-019 Read event = rd_valid_o AND rd_ready_i; the head pops on that clock edge.
REQ-020 rd_valid_o SHALL equal NOT empty_o; rd_data_o/rd_err_o SHALL be the head entry, valid whenever rd_valid_o=1.
REQ-021 Write-to-rd_valid_o latency SHALL be one cycle; there is no fall-through when empty.
REQ-022 A read event SHALL not depend on rd_ready_i when empty; rd_ready_i while empty is ignored.
REQ-023 A write while full without a same-cycle read SHALL be dropped; overflow_o sets the next cycle; contents unchanged.
REQ-024 A write while full with a same-cycle read SHALL be accepted; level stays DEPTH; overflow_o unchanged.
REQ-025 Simultaneous read and write at any level SHALL leave level_o unchanged and preserve order.
REQ-026 Read and write pointers are $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; full/empty derive from a separate level counter.
REQ-027 clr_i SHALL empty the FIFO and clear overflow_o next cycle; clr_i overrides a same-cycle read or write, and that write is discarded.
REQ-028 overflow_o SHALL hold until clr_i or reset.
REQ-029 irq_o, full_o, and empty_o SHALL be registered or derived from registered level only; there is no combinational path from inputs.

Reset
REQ-030 On rst_i assertion, regardless of clock: pointers and level 0, empty_o=1, full_o=0, rd_valid_o=0, overflow_o=0, irq_o=0.
REQ-031 Storage array contents need not be reset; rd_data_o/rd_err_o are don't-care while rd_valid_o=0.
REQ-032 Reset mid-operation SHALL discard all entries; the first write after release is the new head.

Structure
REQ-033 The entry struct (8-bit data plus err bit) and the default DEPTH/THRESH constants SHALL live in the shared UART package.
REQ-034 The block SHALL instantiate one sub-module, uart_rx_fifo_mem: a DEPTH x 9 register array with one write port and one asynchronous read port.
REQ-035 Pointer, level, overflow, and irq control SHALL reside in uart_rx_fifo itself.

Verification
REQ-036 Reset, then rx_int_i with data_i=0xA5 -> next cycle rd_valid_o=1, rd_data_o=0xA5, rd_err_o=0, level_o=1.
REQ-037 Write 0x11, then err_int_i with 0x22, then rx_int_i+err_int_i with 0x33; drain with rd_ready_i=1 -> reads 0x11/0, 0x22/1, 0x33/1 in order, then empty_o=1.
REQ-038 DEPTH=8: 9 writes, no reads -> full_o=1, overflow_o=1, 8 entries read back in order, and the 9th byte is absent.
REQ-039 Full FIFO, write 0x77 with a same-cycle read -> level_o=8, overflow_o=0, and 0x77 emerges last after DEPTH reads.
REQ-040 Continuous write+read for 20 cycles from level 3 -> level_o stays 3, pointers wrap, and data order is preserved; irq_o=0 at THRESH=4.
REQ-041 Level 5 with overflow set; pulse clr_i with a same-cycle write -> next cycle level_o=0, overflow_o=0, irq_o=0; assert rst_i asynchronously mid-burst -> outputs go to reset values immediately.
